pwm_fade_ctrl: RTL

//  Memory-mapped N-channel PWM controller with per-channel hardware fading, successor to the fixed 3-channel LED PWM.

---
 rtl/pwm_pkg.sv | 10 +
 rtl/pwm_fade_channel.sv | 62 ++++++
 rtl/pwm_fade_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Register map constants shared by the PWM fade controller and its bench.
package pwm_pkg;
   localparam int TARGET_BASE   = 'h00;
   localparam int CTRL_ADDR     = 'h10;
   localparam int FADE_DIV_ADDR = 'h11;
   localparam int STATUS_ADDR   = 'h12;
   localparam int CUR_BASE      = 'h20;
   localparam int CTRL_EN_BIT   = 0;
   localparam int FADE_DIV_W    = 16;
endpackage

// File: rtl/pwm_fade_channel.sv
// One PWM channel: target/current/active duty and the output compare flop.
// Build option PWM_FADE_EN selects the stepping fade engine; otherwise CUR
// tracks TARGET directly.
module pwm_fade_channel
   import pwm_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [PWM_BITS-1:0] i_ctr,
   input  logic                i_tick,
   input  logic                i_wrap,
   input  logic                i_en,
   input  logic                i_we,
   input  logic [PWM_BITS-1:0] i_data,
   output logic [PWM_BITS-1:0] o_target,
   output logic [PWM_BITS-1:0] o_cur,
   output logic                o_status,
   output logic                o_pwm
);
   logic [PWM_BITS-1:0] r_target, r_cur, r_act;
   logic                r_pwm;

   // Target register, written by the CPU at any time (also while disabled)
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)  r_target <= '0;
      else if (i_we) r_target <= i_data;

`ifdef PWM_FADE_EN
   // Step CUR one LSB towards the (pre-write) TARGET on each fade tick
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cur <= '0;
      else if (i_tick) begin
         if (r_cur < r_target)      r_cur <= r_cur + 1'b1;
         else if (r_cur > r_target) r_cur <= r_cur - 1'b1;
      end
`else
   logic w_unused;
   assign w_unused = i_tick;

   // No fade engine: CUR follows TARGET while enabled, frozen otherwise
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cur <= '0;
      else if (i_en) r_cur <= r_target;
`endif

   // Active duty changes only at the period wrap so no period is cut short
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)    r_act <= '0;
      else if (i_wrap) r_act <= r_cur;

   // Registered compare; forced low one cycle after disable
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_pwm <= 1'b0;
      else          r_pwm <= i_en & (r_act > i_ctr);

   assign o_target = r_target;
   assign o_cur    = r_cur;
   assign o_status = (r_cur != r_target);
   assign o_pwm    = r_pwm;
endmodule

// File: rtl/pwm_fade_ctrl.sv
// Memory-mapped N-channel PWM controller with hardware fading.
// Top holds bus decode, period counter, fade prescaler and read mux.
// Define PWM_FADE_EN to build the fade engine, FADE_DIV and STATUS.
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int CHANNELS     = 3,
   parameter int BITS         = 16,
   parameter int ADDRESS_BITS = 8,
   parameter int PWM_BITS     = 8
) (
   input  logic                    CLK,
   input  logic                    RSTb,
   input  logic [ADDRESS_BITS-1:0] ADDRESS,
   input  logic [BITS-1:0]         DATA_IN,
   output logic [BITS-1:0]         DATA_OUT,
   input  logic                    WRb,
   output logic [CHANNELS-1:0]     PWM_OUT
);
   // Last counter value FS-1: period is FS cycles
   localparam logic [PWM_BITS-1:0] CTR_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

   logic [31:0]                        w_addr;
   logic                               w_wr, w_wrap, w_tick, w_unused;
   logic                               r_en;
   logic [PWM_BITS-1:0]                r_ctr;
   logic [CHANNELS-1:0][PWM_BITS-1:0]  w_target, w_cur;
   logic [CHANNELS-1:0]                w_status;

   assign w_addr   = 32'(ADDRESS);
   assign w_wr     = !WRb;
   assign w_wrap   = r_en && (r_ctr == CTR_LAST);
   assign w_unused = ^{DATA_IN, w_status};

   // Global enable bit
   always_ff @(posedge CLK or negedge RSTb)
      if (!RSTb) r_en <= 1'b0;
      else if (w_wr && w_addr == 32'(CTRL_ADDR)) r_en <= DATA_IN[CTRL_EN_BIT];

   // Period counter 0..FS-1, held at 0 while disabled so enable restarts cleanly
   always_ff @(posedge CLK or negedge RSTb)
      if (!RSTb)                r_ctr <= '0;
      else if (!r_en || w_wrap) r_ctr <= '0;
      else                      r_ctr <= r_ctr + 1'b1;

`ifdef PWM_FADE_EN
   logic [FADE_DIV_W-1:0] r_fade_div, r_ps;
   logic                  w_div_we;

   assign w_div_we = w_wr && (w_addr == 32'(FADE_DIV_ADDR));
   assign w_tick   = r_en && (r_ps == r_fade_div);

   // Fade divider register
   always_ff @(posedge CLK or negedge RSTb)
      if (!RSTb)         r_fade_div <= '0;
      else if (w_div_we) r_fade_div <= DATA_IN[FADE_DIV_W-1:0];

   // Prescaler 0..FADE_DIV; a divider write restarts it immediately
   always_ff @(posedge CLK or negedge RSTb)
      if (!RSTb)                          r_ps <= '0;
      else if (!r_en || w_div_we || w_tick) r_ps <= '0;
      else                                r_ps <= r_ps + 1'b1;
`else
   assign w_tick = 1'b0;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic w_we;
      assign w_we = w_wr && (w_addr == 32'(TARGET_BASE + i));
      pwm_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
         .i_clk    (CLK),
         .i_rst_n  (RSTb),
         .i_ctr    (r_ctr),
         .i_tick   (w_tick),
         .i_wrap   (w_wrap),
         .i_en     (r_en),
         .i_we     (w_we),
         .i_data   (DATA_IN[PWM_BITS-1:0]),
         .o_target (w_target[i]),
         .o_cur    (w_cur[i]),
         .o_status (w_status[i]),
         .o_pwm    (PWM_OUT[i])
      );
   end

   // Combinational read mux; unmapped addresses and unused bits read 0
   always_comb begin
      DATA_OUT = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_addr == 32'(TARGET_BASE + i)) DATA_OUT[PWM_BITS-1:0] = w_target[i];
         if (w_addr == 32'(CUR_BASE + i))    DATA_OUT[PWM_BITS-1:0] = w_cur[i];
      end
      if (w_addr == 32'(CTRL_ADDR)) DATA_OUT[CTRL_EN_BIT] = r_en;
`ifdef PWM_FADE_EN
      if (w_addr == 32'(FADE_DIV_ADDR)) DATA_OUT[FADE_DIV_W-1:0] = r_fade_div;
      if (w_addr == 32'(STATUS_ADDR))   DATA_OUT[CHANNELS-1:0]   = w_status;
`endif
   end
endmodule
